dma_spi_tx: RTL

//  SPI master (mode 0, MSB first) that serialises the 51-byte / 408-bit timing-parameter frame
//  (TIME..Tblank2) on CS/SCLK/MOSI. It is the transmit end of the MCU->FPGA DMA SPI link.

---
 rtl/dma_spi_pkg.sv | 29 ++
 rtl/dma_spi_tx_if.sv | 32 +++
 rtl/spi_half_tick.sv | 30 +++
 rtl/dma_spi_tx.sv | 121 ++++++++++++
 4 files changed

// File: rtl/dma_spi_pkg.sv
// Shared frame layout and FSM encoding for the DMA SPI link (transmitter and receiver).
package dma_spi_pkg;

  localparam int FRAME_BITS = 408;

  // Field order is MSB first on the wire; the receiver relies on this exact layout.
  typedef struct packed {
    logic [63:0] time_val;
    logic [47:0] freq;
    logic [47:0] freq_step;
    logic [31:0] freq_rate;
    logic [63:0] time_start;
    logic [15:0] n_impulse;
    logic [7:0]  type_impulse;
    logic [31:0] interval_ti;
    logic [31:0] interval_tp;
    logic [31:0] tblank1;
    logic [31:0] tblank2;
  } dma_frame_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/dma_spi_tx_if.sv
// Request, parameter fields and SPI pins of the DMA SPI transmitter.
interface dma_spi_tx_if;
  logic        START;
  logic [63:0] TIME;
  logic [47:0] FREQ;
  logic [47:0] FREQ_STEP;
  logic [31:0] FREQ_RATE;
  logic [63:0] TIME_START;
  logic [15:0] N_impulse;
  logic [7:0]  TYPE_impulse;
  logic [31:0] Interval_Ti;
  logic [31:0] Interval_Tp;
  logic [31:0] Tblank1;
  logic [31:0] Tblank2;
  logic        CS;
  logic        SCLK;
  logic        MOSI;
  logic        BUSY;
  logic        DONE;

  modport master (
    output START, TIME, FREQ, FREQ_STEP, FREQ_RATE, TIME_START, N_impulse,
           TYPE_impulse, Interval_Ti, Interval_Tp, Tblank1, Tblank2,
    input  CS, SCLK, MOSI, BUSY, DONE
  );

  modport slave (
    input  START, TIME, FREQ, FREQ_STEP, FREQ_RATE, TIME_START, N_impulse,
           TYPE_impulse, Interval_Ti, Interval_Tp, Tblank1, Tblank2,
    output CS, SCLK, MOSI, BUSY, DONE
  );
endinterface

// File: rtl/spi_half_tick.sv
// SCLK half-period divider: one-cycle tick every HALF_DIV enabled clocks.
module spi_half_tick #(
  parameter int HALF_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic clk_en,
  output logic tick
);
  localparam int CW = $clog2(HALF_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

  logic [CW-1:0] cnt_r;

  assign tick = clk_en && (cnt_r == LAST);

  // Half-period counter, held at zero while the transmitter is idle.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (clk_en) begin
      if (cnt_r == LAST) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end
endmodule

// File: rtl/dma_spi_tx.sv
// SPI mode-0 master that sends the 408-bit DMA parameter frame MSB first.
module dma_spi_tx
  import dma_spi_pkg::*;
#(
  parameter int HALF_DIV = 2,
  parameter int GAP_CYC  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  dma_spi_tx_if.slave  bus
);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
  localparam logic [8:0]    LAST_BIT = 9'(FRAME_BITS);

  tx_state_t             state_r;
  logic [FRAME_BITS-1:0] shreg_r;
  logic [8:0]            bit_cnt_r;
  logic [GW-1:0]         gap_cnt_r;
  logic                  cs_r, sclk_r, mosi_r, busy_r, done_r;
  logic                  tick_s;
  dma_frame_t            snap_s;

  assign snap_s = '{time_val: bus.TIME, freq: bus.FREQ, freq_step: bus.FREQ_STEP,
                    freq_rate: bus.FREQ_RATE, time_start: bus.TIME_START,
                    n_impulse: bus.N_impulse, type_impulse: bus.TYPE_impulse,
                    interval_ti: bus.Interval_Ti, interval_tp: bus.Interval_Tp,
                    tblank1: bus.Tblank1, tblank2: bus.Tblank2};

  spi_half_tick #(.HALF_DIV(HALF_DIV)) u_half_tick (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_r == ST_IDLE),
    .clk_en (clk_en),
    .tick   (tick_s)
  );

  // Frame FSM; bit_cnt_r counts SCLK rising edges, the frame ends on the fall after the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      shreg_r   <= {FRAME_BITS{1'b0}};
      bit_cnt_r <= 9'd0;
      gap_cnt_r <= {GW{1'b0}};
      cs_r      <= 1'b1;
      sclk_r    <= 1'b0;
      mosi_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else if (clk_en) begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.START) begin
            shreg_r   <= snap_s;
            cs_r      <= 1'b0;
            mosi_r    <= snap_s[FRAME_BITS-1];
            busy_r    <= 1'b1;
            bit_cnt_r <= 9'd0;
            state_r   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tick_s) begin
            sclk_r    <= 1'b1;
            bit_cnt_r <= 9'd1;
            state_r   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (tick_s) begin
            if (!sclk_r) begin
              sclk_r    <= 1'b1;
              bit_cnt_r <= bit_cnt_r + 9'd1;
            end else if (bit_cnt_r == LAST_BIT) begin
              sclk_r  <= 1'b0;
              mosi_r  <= 1'b0;
              state_r <= ST_HOLD;
            end else begin
              sclk_r  <= 1'b0;
              shreg_r <= {shreg_r[FRAME_BITS-2:0], 1'b0};
              mosi_r  <= shreg_r[FRAME_BITS-2];
            end
          end
        end
        ST_HOLD: begin
          if (tick_s) begin
            cs_r      <= 1'b1;
            gap_cnt_r <= {GW{1'b0}};
            state_r   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r + {{(GW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cs_r    <= 1'b1;
          sclk_r  <= 1'b0;
          mosi_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end else begin
      done_r <= 1'b0;
    end
  end

  assign bus.CS   = cs_r;
  assign bus.SCLK = sclk_r;
  assign bus.MOSI = mosi_r;
  assign bus.BUSY = busy_r;
  assign bus.DONE = done_r;
endmodule
